// File: rtl/c432_irq_dispatch.sv
// Purpose: debounce c432 bus-request/channel words and queue qualified events for the host.
// Latency: a word held from cycle 0 is pushed at the end of cycle STABLE_CYCLES, visible the next cycle.
// Backpressure: valid/ready head; push into a full FIFO without a pop drops the event and flags overflow.
`timescale 1ns/1ps
module c432_irq_dispatch #(
    parameter int STABLE_CYCLES = 2,
    parameter int DEPTH         = 4,
    parameter int LW            = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          bus_a_i,
    input  logic          bus_b_i,
    input  logic          bus_c_i,
    input  logic [3:0]    chan_i,
    input  logic          sample_en_i,
    output logic          irq_valid_o,
    input  logic          irq_ready_i,
    output logic [1:0]    irq_bus_o,
    output logic [3:0]    irq_chan_o,
    output logic [LW-1:0] fifo_level_o,
    output logic          overflow_o,
    output logic [7:0]    drop_cnt_o,
    input  logic          clear_ovf_i
);

    localparam int             PW      = $clog2(DEPTH);
    localparam logic [2:0]     STB_C   = 3'(STABLE_CYCLES);
    localparam logic [LW-1:0]  DEPTH_L = LW'(DEPTH);
    localparam bit             STB_ONE = (STABLE_CYCLES == 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_QUAL = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    // Sampled word: {bus code, channel}; forced to zero when idle
    logic [1:0] w_smp_bus;
    logic       w_smp_act;
    logic       r_smp_act;
    logic [5:0] r_smp_word;

    state_t     r_state, w_state_nxt;
    logic [2:0] r_cnt, w_cnt_nxt;
    logic [5:0] r_cur, w_cur_nxt;
    logic       w_push;
    logic       w_new;

    logic [5:0]    r_mem [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [LW-1:0] r_level;
    logic          w_valid;
    logic          w_pop;
    logic          w_full;
    logic          w_wr;
    logic          w_drop;
    logic          r_ovf;
    logic [7:0]    r_drop_cnt;

    // Encode the request flags with priority A > B > C and decide whether the sample is idle
    always_comb begin
        w_smp_bus = 2'b00;
        if (bus_a_i) begin
            w_smp_bus = 2'b00;
        end else if (bus_b_i) begin
            w_smp_bus = 2'b01;
        end else if (bus_c_i) begin
            w_smp_bus = 2'b10;
        end
        w_smp_act = sample_en_i & (bus_a_i | bus_b_i | bus_c_i);
    end

    // Register the input word every cycle so glitches in the core are seen as short-lived samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_smp_act  <= 1'b0;
            r_smp_word <= 6'd0;
        end else begin
            r_smp_act  <= w_smp_act;
            r_smp_word <= w_smp_act ? {w_smp_bus, chan_i} : 6'd0;
        end
    end

    // Qualifier state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 3'd0;
            r_cur   <= 6'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_cur   <= w_cur_nxt;
        end
    end

    // Qualifier next state: a new non-idle word restarts counting, an idle sample abandons it
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_cur_nxt   = r_cur;
        w_push      = 1'b0;
        w_new       = r_smp_act && ((r_state == S_IDLE) || (r_smp_word != r_cur));
        if (!r_smp_act) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = 3'd0;
        end else if (w_new) begin
            w_cur_nxt = r_smp_word;
            w_cnt_nxt = 3'd1;
            if (STB_ONE) begin
                w_push      = 1'b1;
                w_state_nxt = S_HOLD;
            end else begin
                w_state_nxt = S_QUAL;
            end
        end else begin
            case (r_state)
                S_QUAL: begin
                    w_cnt_nxt = r_cnt + 3'd1;
                    if ((r_cnt + 3'd1) == STB_C) begin
                        w_push      = 1'b1;
                        w_state_nxt = S_HOLD;
                    end
                end
                S_HOLD: begin
                    w_state_nxt = S_HOLD;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = 3'd0;
                end
            endcase
        end
    end

    assign w_valid = (r_level != '0);
    assign w_pop   = w_valid & irq_ready_i;
    assign w_full  = (r_level == DEPTH_L);
    assign w_wr    = w_push & (~w_full | w_pop);
    assign w_drop  = w_push & w_full & ~w_pop;

    // FIFO storage and pointers; a pop frees the slot a same-cycle push into a full FIFO needs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 6'd0;
            end
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_wr) begin
                r_mem[r_wptr] <= r_cur_push_word(w_cur_nxt);
                r_wptr        <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_wr, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // The word being pushed is always the one the qualifier is tracking after this cycle
    function automatic logic [5:0] r_cur_push_word(input logic [5:0] word);
        return word;
    endfunction

    // Sticky overflow and saturating drop count; a drop in the clear cycle takes precedence
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf      <= 1'b0;
            r_drop_cnt <= 8'd0;
        end else if (w_drop) begin
            r_ovf      <= 1'b1;
            r_drop_cnt <= clear_ovf_i ? 8'd1 :
                          (r_drop_cnt == 8'hFF) ? 8'hFF : r_drop_cnt + 8'd1;
        end else if (clear_ovf_i) begin
            r_ovf      <= 1'b0;
            r_drop_cnt <= 8'd0;
        end
    end

    assign irq_valid_o  = w_valid;
    assign irq_bus_o    = w_valid ? r_mem[r_rptr][5:4] : 2'b00;
    assign irq_chan_o   = w_valid ? r_mem[r_rptr][3:0] : 4'd0;
    assign fifo_level_o = r_level;
    assign overflow_o   = r_ovf;
    assign drop_cnt_o   = r_drop_cnt;

endmodule

// File: tb/tb_c432_irq_dispatch.sv
// Purpose: randomized and directed checks of c432_irq_dispatch against a run-length/queue model.
// Latency: model posts when a non-idle word has been seen exactly STABLE_CYCLES times in a row.
// Backpressure: model queue pops on valid&ready, drops on push into a full queue without a pop.
`timescale 1ns/1ps
module tb_c432_irq_dispatch;

    localparam int S  = 2;
    localparam int D  = 4;
    localparam int LW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          bus_a_i = 1'b0;
    logic          bus_b_i = 1'b0;
    logic          bus_c_i = 1'b0;
    logic [3:0]    chan_i = 4'd0;
    logic          sample_en_i = 1'b1;
    logic          irq_valid_o;
    logic          irq_ready_i = 1'b1;
    logic [1:0]    irq_bus_o;
    logic [3:0]    irq_chan_o;
    logic [LW-1:0] fifo_level_o;
    logic          overflow_o;
    logic [7:0]    drop_cnt_o;
    logic          clear_ovf_i = 1'b0;

    int total = 0;
    int bad   = 0;

    c432_irq_dispatch #(.STABLE_CYCLES(S), .DEPTH(D)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus_a_i      (bus_a_i),
        .bus_b_i      (bus_b_i),
        .bus_c_i      (bus_c_i),
        .chan_i       (chan_i),
        .sample_en_i  (sample_en_i),
        .irq_valid_o  (irq_valid_o),
        .irq_ready_i  (irq_ready_i),
        .irq_bus_o    (irq_bus_o),
        .irq_chan_o   (irq_chan_o),
        .fifo_level_o (fifo_level_o),
        .overflow_o   (overflow_o),
        .drop_cnt_o   (drop_cnt_o),
        .clear_ovf_i  (clear_ovf_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [5:0] mq[$];
    int         run = 0;
    logic [6:0] last_w = 7'd0;
    bit         pend = 1'b0;
    logic [5:0] pend_word = 6'd0;
    bit         m_ovf = 1'b0;
    int         m_drops = 0;
    bit         m_full, m_pop, m_drop;
    logic [6:0] m_w;

    // {active, bus code, channel}; zero when idle
    function automatic logic [6:0] raw_word();
        logic [1:0] bc;
        if (!sample_en_i || !(bus_a_i || bus_b_i || bus_c_i)) return 7'd0;
        bc = bus_a_i ? 2'd0 : (bus_b_i ? 2'd1 : 2'd2);
        return {1'b1, bc, chan_i};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            run     = 0;
            last_w  = 7'd0;
            pend    = 1'b0;
            m_ovf   = 1'b0;
            m_drops = 0;
        end else begin
            m_full = (mq.size() == D);
            m_pop  = (mq.size() != 0) && irq_ready_i;
            m_drop = 1'b0;
            if (m_pop) void'(mq.pop_front());
            if (pend) begin
                if (!m_full || m_pop) mq.push_back(pend_word);
                else m_drop = 1'b1;
            end
            if (m_drop) begin
                m_ovf   = 1'b1;
                m_drops = clear_ovf_i ? 1 : ((m_drops < 255) ? m_drops + 1 : 255);
            end else if (clear_ovf_i) begin
                m_ovf   = 1'b0;
                m_drops = 0;
            end
            m_w = raw_word();
            if (!m_w[6]) run = 0;
            else if (m_w == last_w && run > 0) run++;
            else run = 1;
            last_w    = m_w;
            pend      = (run == S);
            pend_word = m_w[5:0];
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        logic [5:0] head;
        head = (mq.size() != 0) ? mq[0] : 6'd0;
        chk("model_valid", irq_valid_o, (mq.size() != 0) ? 1 : 0);
        chk("model_bus",   irq_bus_o, head[5:4]);
        chk("model_chan",  irq_chan_o, head[3:0]);
        chk("model_level", fifo_level_o, mq.size());
        chk("model_ovf",   overflow_o, m_ovf);
        chk("model_drops", drop_cnt_o, m_drops);
    end

    // ---------------- stimulus helpers ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit a, input bit b, input bit c, input logic [3:0] ch);
        bus_a_i = a;
        bus_b_i = b;
        bus_c_i = c;
        chan_i  = ch;
    endtask

    task automatic idle_in();
        drive(1'b0, 1'b0, 1'b0, 4'd0);
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_valid"}, irq_valid_o, 0);
        chk({nm, "_bus"},   irq_bus_o, 0);
        chk({nm, "_chan"},  irq_chan_o, 0);
        chk({nm, "_level"}, fifo_level_o, 0);
        chk({nm, "_ovf"},   overflow_o, 0);
        chk({nm, "_drops"}, drop_cnt_o, 0);
    endtask

    initial begin
        int hold;
        #2 rst_n = 1'b0;
        #1 chk_all_zero("reset");
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (2) next_cycle();

        // Basic post: bus A, chan 5, held 6 cycles
        irq_ready_i = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 4'h5);
        for (int c = 0; c <= 6; c++) begin
            if (c == 6) idle_in();
            @(negedge clk);
            chk("basic_valid", irq_valid_o, (c == 3) ? 1 : 0);
            if (c == 3) begin
                chk("basic_bus", irq_bus_o, 0);
                chk("basic_chan", irq_chan_o, 5);
            end
            next_cycle();
        end
        repeat (4) next_cycle();

        // Glitch filter: 3,4,3,4 on bus B then hold 9 from cycle 4
        for (int c = 0; c <= 10; c++) begin
            drive(1'b0, 1'b1, 1'b0, (c < 4) ? ((c % 2 == 0) ? 4'h3 : 4'h4) : 4'h9);
            @(negedge clk);
            chk("glitch_valid", irq_valid_o, (c == 7) ? 1 : 0);
            if (c == 7) begin
                chk("glitch_bus", irq_bus_o, 1);
                chk("glitch_chan", irq_chan_o, 9);
            end
            next_cycle();
        end
        idle_in();
        repeat (4) next_cycle();

        // Priority: B and C together, B wins
        drive(1'b0, 1'b1, 1'b1, 4'hC);
        for (int c = 0; c <= 5; c++) begin
            @(negedge clk);
            if (c == 3) begin
                chk("prio_valid", irq_valid_o, 1);
                chk("prio_bus", irq_bus_o, 1);
                chk("prio_chan", irq_chan_o, 12);
            end
            next_cycle();
        end
        idle_in();
        repeat (4) next_cycle();

        // Overflow: six distinct words with the host stalled
        irq_ready_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b0, 1'b0, 4'(i + 1));
            repeat (3) next_cycle();
        end
        idle_in();
        repeat (4) next_cycle();
        @(negedge clk);
        chk("ovf_level", fifo_level_o, 4);
        chk("ovf_flag", overflow_o, 1);
        chk("ovf_drops", drop_cnt_o, 2);
        next_cycle();
        irq_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("drain_valid", irq_valid_o, 1);
            chk("drain_chan", irq_chan_o, i + 1);
            next_cycle();
        end
        @(negedge clk);
        chk("drain_level", fifo_level_o, 0);
        next_cycle();
        clear_ovf_i = 1'b1;
        next_cycle();
        clear_ovf_i = 1'b0;
        @(negedge clk);
        chk("clear_ovf", overflow_o, 0);
        chk("clear_drops", drop_cnt_o, 0);
        next_cycle();

        // Full FIFO with push and pop on the same edge
        irq_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 1'b0, 4'(i + 1));
            repeat (3) next_cycle();
        end
        idle_in();
        repeat (3) next_cycle();
        drive(1'b0, 1'b1, 1'b0, 4'h5);
        next_cycle();
        next_cycle();
        irq_ready_i = 1'b1;
        @(negedge clk);
        chk("pp_head_before", irq_chan_o, 1);
        next_cycle();
        irq_ready_i = 1'b0;
        idle_in();
        @(negedge clk);
        chk("pp_level", fifo_level_o, 4);
        chk("pp_drops", drop_cnt_o, 0);
        chk("pp_ovf", overflow_o, 0);
        chk("pp_head_after", irq_chan_o, 2);
        next_cycle();
        irq_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("pp_order", irq_chan_o, i + 2);
            next_cycle();
        end
        repeat (2) next_cycle();

        // Reset mid-operation: level 3 and a word half-qualified
        irq_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b1, 4'(i + 7));
            repeat (3) next_cycle();
        end
        idle_in();
        repeat (3) next_cycle();
        @(negedge clk);
        chk("pre_rst_level", fifo_level_o, 3);
        next_cycle();
        drive(1'b1, 1'b0, 1'b0, 4'hE);
        next_cycle();
        next_cycle();
        #2 rst_n = 1'b0;
        idle_in();
        #1 chk_all_zero("midrst");
        next_cycle();
        next_cycle();
        #2 rst_n = 1'b1;
        irq_ready_i = 1'b1;
        for (int c = 0; c < 10; c++) begin
            next_cycle();
            @(negedge clk);
            chk("post_rst_quiet", irq_valid_o, 0);
        end
        next_cycle();

        // Randomized traffic
        hold = 0;
        for (int n = 0; n < 2000; n++) begin
            if (hold == 0) begin
                drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)));
                sample_en_i = ($urandom_range(0, 9) != 0);
                hold = $urandom_range(1, 4);
            end
            hold--;
            irq_ready_i = ((n / 400) % 2 == 0) ? ($urandom_range(0, 3) == 0)
                                               : ($urandom_range(0, 3) != 0);
            clear_ovf_i = ($urandom_range(0, 49) == 0);
            next_cycle();
        end
        idle_in();
        sample_en_i = 1'b1;
        clear_ovf_i = 1'b0;
        irq_ready_i = 1'b1;
        repeat (10) next_cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/c432_irq_dispatch.md
# c432_irq_dispatch

Sequential dispatch stage directly downstream of the c432 27-channel priority interrupt controller. It samples c432's three bus-request flags (N223, N329, N370) and its 4-bit channel code ({N421, N430, N431, N432}). It posts an event only after the word has been stable for a programmable number of cycles, which filters combinational glitches in the core. Qualified events are buffered in a small FIFO and presented to the host through a valid/ready handshake, with sticky overflow reporting.

## Interface
- STABLE_CYCLES, 2: consecutive identical non-idle samples required before posting; legal range 1..7.
- DEPTH, 4: FIFO entries; power of two, 2..16.
- LW: derived, clog2(DEPTH)+1.
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous assert, active low.
- bus_a_i  input  1  c432 N223; high = bus A request.
- bus_b_i  input  1  c432 N329; high = bus B request.
- bus_c_i  input  1  c432 N370; high = bus C request.
- chan_i  input  4  {N421, N430, N431, N432}; channel code.
- sample_en_i  input  1  low forces inputs to be treated as idle.
- irq_valid_o  output  1  FIFO head valid.
- irq_ready_i  input  1  host accepts head.
- irq_bus_o  output  2  head bus code: 00 = A, 01 = B, 10 = C; 11 never produced.
- irq_chan_o  output  4  head channel code.
- fifo_level_o  output  LW  entries held.
- overflow_o  output  1  sticky; an event was dropped.
- drop_cnt_o  output  8  dropped events, saturating at 255.
- clear_ovf_i  input  1  clears overflow_o and drop_cnt_o.

## Operation
- Word = {bus code, chan_i}, 6 bits.
  - Bus code uses priority A > B > C.
  - Word is idle if no bus flag is high or sample_en_i = 0; chan_i is ignored when idle.
- Inputs are registered every cycle.
- Qualifier FSM:
  - IDLE: waits for a non-idle sample. Goes to QUAL with cnt = 1.
  - QUAL, same word sampled: cnt++.
  - QUAL, different non-idle word: restart with cnt = 1 on the new word.
  - QUAL, idle sample: go to IDLE.
  - QUAL, cnt reaches STABLE_CYCLES: issue a push, go to HOLD.
  - HOLD, same word: stay; no re-post, however long the word is held.
  - HOLD, different non-idle word: go to QUAL with cnt = 1.
  - HOLD, idle sample: go to IDLE.
  - With STABLE_CYCLES = 1, the first non-idle sample pushes directly and the FSM enters HOLD.
- FIFO behaviour:
  - Pop occurs on irq_valid_o && irq_ready_i.
  - Push and pop in the same cycle are always legal, including when full; level is unchanged.
  - Push while full with no pop: entry dropped, overflow_o set, drop_cnt_o incremented (saturating).
  - Pop while empty is impossible, because valid is low.
- Outputs:
  - irq_bus_o and irq_chan_o are the FIFO head. They hold stable while valid && !ready.
  - They are 0 when the FIFO is empty.
- Overflow control: clear_ovf_i zeroes overflow_o and drop_cnt_o. If a drop occurs in the same cycle as the clear, the drop wins: overflow_o = 1 and drop_cnt_o = 1.

## Timing
- Reset (rst_n low), applied immediately and asynchronously:
  - FSM = IDLE, cnt = 0, FIFO empty.
  - All outputs 0: irq_valid_o, irq_bus_o, irq_chan_o, fifo_level_o, overflow_o, drop_cnt_o.
  - Pending qualification is discarded; nothing is replayed after release.
- Latency:
  - A word first present in cycle 0 (captured at the end of cycle 0) and held is pushed at the end of cycle STABLE_CYCLES.
  - With the FIFO empty, irq_valid_o is high from cycle STABLE_CYCLES + 1.
- Level update: fifo_level_o updates on the same edge as the push or pop.
- Head handoff: after a pop, the next entry appears on the following cycle with no bubble.
- Throughput: at most one push and one pop per cycle.

## Test plan
- Basic post: STABLE_CYCLES = 2, bus_a_i = 1, chan_i = 4'h5 held 6 cycles, irq_ready_i = 1.
  - Required: exactly one event; irq_valid_o high in cycle 3 only; irq_bus_o = 00, irq_chan_o = 5.
- Glitch filter: chan_i toggles 3→4→3→4 on bus B for 4 cycles, then holds 4'h9.
  - Required: a single event, bus 01, chan 9, valid 3 cycles after 9 first appears.
- Priority: bus_a_i = 0, bus_b_i = 1, bus_c_i = 1, chan_i = 4'hC held.
  - Required: irq_bus_o = 01, irq_chan_o = C.
- Overflow: DEPTH = 4, irq_ready_i = 0, six distinct qualified words.
  - Required: fifo_level_o = 4, overflow_o = 1, drop_cnt_o = 2.
  - Then irq_ready_i = 1: the first four words drain in order and the level returns to 0.
  - Then clear_ovf_i: overflow_o and drop_cnt_o return to 0.
- Full with simultaneous push and pop: FIFO at 4, irq_ready_i = 1 on the push edge.
  - Required: no drop, level stays 4, order preserved.
- Reset mid-operation: assert rst_n low with level 3 and the FSM in QUAL.
  - Required: all outputs 0 immediately.
  - After release with inputs idle: no event for 10 cycles.
